// File: rtl/tff_bank_arbiter_if.sv
// Requester-side bus of the shared toggle/clear flip-flop bank.
// Mask lanes are packed so requester i occupies bits [i*W +: W].
interface tff_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_clr;
  logic [NREQ-1:0][W-1:0]  req_mask;
  logic [NREQ-1:0]         req_ready;
  logic [W-1:0]            q;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] gnt_id;

  modport master (
    output req_valid, req_clr, req_mask,
    input  req_ready, q, busy, gnt_id
  );

  modport slave (
    input  req_valid, req_clr, req_mask,
    output req_ready, q, busy, gnt_id
  );
endinterface

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit bank of reset/toggle flip-flops
// between NREQ requesters, with GAP settle cycles after each operation.

module tff_bank_arbiter_rt_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic r,
  input  logic t,
  output logic q
);
  // Clear wins over toggle, as in a single RT flip-flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       q <= 1'b0;
    else if (clr | r) q <= 1'b0;
    else if (t)       q <= ~q;
  end
endmodule

module tff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int GAP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_all,
  tff_bank_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t          state, nxt;
  logic [IDW-1:0]  ptr, win, pick, idx;
  logic [3:0]      gap_cnt;
  logic [NREQ-1:0] ready;
  logic [W-1:0]    tog, clr_bits, q_bits;
  logic            any_vld, fire;
  int              s;

  assign any_vld = |bus.req_valid;
  assign fire    = (state == S_GRANT) && bus.req_valid[win] && !clr_all;

  // Walk offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    s    = 0;
    for (int o = NREQ-1; o >= 0; o--) begin
      s = int'(ptr) + o;
      if (s >= NREQ) s = s - NREQ;
      idx = IDW'(s);
      if (bus.req_valid[idx]) pick = idx;
    end
  end

  always_comb begin
    nxt      = state;
    ready    = '0;
    tog      = '0;
    clr_bits = '0;
    case (state)
      S_IDLE:  if (any_vld) nxt = S_GRANT;
      S_GRANT: begin
        if (fire) begin
          ready[win] = 1'b1;
          if (bus.req_clr[win]) clr_bits = bus.req_mask[win];
          else                  tog      = bus.req_mask[win];
          nxt = (GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_GAP:   if (gap_cnt == 4'(GAP-1)) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (clr_all) nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      win     <= '0;
      gap_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && any_vld && !clr_all) win <= pick;
      if (fire) ptr <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
      if (state == S_GRANT)   gap_cnt <= '0;
      else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
    end
  end

  for (genvar b = 0; b < W; b++) begin : g_bit
    tff_bank_arbiter_rt_ff u_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_all),
      .r     (clr_bits[b]),
      .t     (tog[b]),
      .q     (q_bits[b])
    );
  end

  assign bus.req_ready = ready;
  assign bus.q         = q_bits;
  assign bus.busy      = (state != S_IDLE);
  assign bus.gnt_id    = win;
endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Directed bench for tff_bank_arbiter (NREQ=4, W=8, GAP=1); samples and drives 1ns after each rising edge.
`timescale 1ns/1ps
module tb_tff_bank_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_all = 1'b0;
  int   errors = 0;
  int   checks = 0;

  tff_bank_arbiter_if #(.NREQ(4), .W(8)) bus ();

  tff_bank_arbiter #(.NREQ(4), .W(8), .GAP(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_all (clr_all),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_clr   = '0;
    bus.req_mask  = '0;
    clr_all       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Posts one operation, waits (bounded) for its ready, holds through the transfer edge.
  task automatic do_op(input int id, input logic c, input logic [7:0] m);
    int n;
    n = 0;
    bus.req_valid[id] = 1'b1;
    bus.req_clr[id]   = c;
    bus.req_mask[id]  = m;
    do begin
      tick();
      n++;
    end while (!bus.req_ready[id] && n < 10);
    checks++;
    if (bus.req_ready[id] !== 1'b1) begin
      errors++;
      $display("FAIL op_ready id=%0d: ready=%b after %0d cycles, required bit %0d set", id, bus.req_ready, n, id);
    end
    tick();
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: q=%h busy=%b ready=%b gnt=%0d, required 00 0 0000 0", bus.q, bus.busy, bus.req_ready, bus.gnt_id);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL idle_after_reset cyc%0d: q=%h busy=%b ready=%b, required 00 0 0000", i, bus.q, bus.busy, bus.req_ready);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid[2] = 1'b1;
    bus.req_mask[2]  = 8'h0F;
    tick();
    checks++;
    if (bus.req_ready !== 4'b0100 || bus.gnt_id !== 2'd2 || bus.busy !== 1'b1 || bus.q !== 8'h00) begin
      errors++;
      $display("FAIL single_grant: ready=%b gnt=%0d busy=%b q=%h, required 0100 2 1 00", bus.req_ready, bus.gnt_id, bus.busy, bus.q);
    end
    tick();
    checks++;
    if (bus.q !== 8'h0F || bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_gap: q=%h busy=%b ready=%b, required 0f 1 0000", bus.q, bus.busy, bus.req_ready);
    end
    bus.req_valid[2] = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.q !== 8'h0F) begin
      errors++;
      $display("FAIL single_idle: busy=%b q=%h, required 0 0f", bus.busy, bus.q);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q [4];
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h0F};
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_mask  = {8'h08, 8'h04, 8'h02, 8'h01};
    for (int g = 0; g < 4; g++) begin
      tick();
      checks++;
      if (bus.gnt_id !== 2'(g) || bus.req_ready !== 4'(1 << g)) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%0d ready=%b, required %0d %b", g, bus.gnt_id, bus.req_ready, g, 4'(1 << g));
      end
      tick();
      checks++;
      if (bus.q !== exp_q[g]) begin
        errors++;
        $display("FAIL rr_q%0d: q=%h, required %h", g, bus.q, exp_q[g]);
      end
      bus.req_valid[g] = 1'b0;
      tick();
    end
  endtask

  task automatic test_clear_toggle();
    do_op(0, 1'b0, 8'hF0);
    checks++;
    if (bus.q !== 8'hFF) begin
      errors++;
      $display("FAIL fill_ff: q=%h, required ff", bus.q);
    end
    do_op(1, 1'b1, 8'hF0);
    checks++;
    if (bus.q !== 8'h0F) begin
      errors++;
      $display("FAIL clear_mask: q=%h, required 0f", bus.q);
    end
    do_op(1, 1'b0, 8'hFF);
    checks++;
    if (bus.q !== 8'hF0) begin
      errors++;
      $display("FAIL toggle_mask: q=%h, required f0", bus.q);
    end
    // Zero mask on req 2 still advances ptr to 3, so 0 beats 2 next.
    do_op(2, 1'b0, 8'h00);
    checks++;
    if (bus.q !== 8'hF0 || bus.gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL zero_mask: q=%h gnt=%0d, required f0 2", bus.q, bus.gnt_id);
    end
    bus.req_mask[0] = 8'h00;
    bus.req_valid   = 4'b0101;
    tick();
    tick();
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL zero_mask_ptr: ready=%b gnt=%0d, required 0001 0", bus.req_ready, bus.gnt_id);
    end
    tick();
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_clr_all();
    int n;
    do_reset();
    do_op(0, 1'b0, 8'h3C);
    bus.req_valid[3] = 1'b1;
    bus.req_mask[3]  = 8'h81;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.req_ready[3] && n < 10);
    checks++;
    if (bus.req_ready !== 4'b1000 || bus.q !== 8'h3C) begin
      errors++;
      $display("FAIL clr_setup: ready=%b q=%h, required 1000 3c", bus.req_ready, bus.q);
    end
    clr_all          = 1'b1;
    bus.req_valid[0] = 1'b1;
    bus.req_mask[0]  = 8'h00;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL clr_ready: ready=%b, required 0000", bus.req_ready);
    end
    tick();
    clr_all = 1'b0;
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_q: q=%h busy=%b, required 00 0", bus.q, bus.busy);
    end
    tick();
    checks++;
    if (bus.gnt_id !== 2'd3 || bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL clr_ptr_kept: gnt=%0d ready=%b, required 3 1000", bus.gnt_id, bus.req_ready);
    end
    tick();
    bus.req_valid[3] = 1'b0;
    checks++;
    if (bus.q !== 8'h81) begin
      errors++;
      $display("FAIL clr_regrant_q: q=%h, required 81", bus.q);
    end
    tick();
    tick();
    tick();
    bus.req_valid[0] = 1'b0;
    checks++;
    if (bus.q !== 8'h81) begin
      errors++;
      $display("FAIL clr_applied_once: q=%h, required 81", bus.q);
    end
  endtask

  task automatic test_reset_mid_gap();
    do_op(2, 1'b0, 8'h55);
    checks++;
    if (bus.busy !== 1'b1 || bus.gnt_id !== 2'd2 || bus.q !== 8'hD4) begin
      errors++;
      $display("FAIL pre_reset_gap: busy=%b gnt=%0d q=%h, required 1 2 d4", bus.busy, bus.gnt_id, bus.q);
    end
    rst_n         = 1'b0;
    bus.req_valid = 4'b1010;
    bus.req_clr   = '0;
    bus.req_mask  = {8'h22, 8'h00, 8'h11, 8'h00};
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: q=%h busy=%b ready=%b gnt=%0d, required 00 0 0000 0", bus.q, bus.busy, bus.req_ready, bus.gnt_id);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.gnt_id !== 2'd1 || bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL post_reset_grant: gnt=%0d ready=%b, required 1 0010", bus.gnt_id, bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.q !== 8'h11) begin
      errors++;
      $display("FAIL post_reset_q: q=%h, required 11", bus.q);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_clear_toggle();
    test_clr_all();
    test_reset_mid_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
